// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : Push-button debouncer. The raw switch is brought into the clk
//               domain through a two-flop synchronizer. A four-state FSM with
//               a stability counter accepts a new level only after it has been
//               seen for DEBOUNCE_CYCLES consecutive cycles. Registered
//               one-cycle rise/fall pulses accompany each accepted change.
//
//               Optional feature macro: SWITCH_DEBOUNCE_TOGGLE_EN
//                 defined   -> led is a press-to-toggle register
//                 undefined -> led follows sw_level
//
// Ports       : clk      in   system clock
//               rst_n    in   asynchronous active-low reset
//               sw       in   raw switch level, asynchronous, 1 = pressed
//               sw_level out  debounced switch level
//               sw_rise  out  one-cycle pulse on accepted 0->1
//               sw_fall  out  one-cycle pulse on accepted 1->0
//               led      out  LED drive
// Revision    : 1.0  initial release
// ============================================================================
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic sw_level,
    output logic sw_rise,
    output logic sw_fall,
    output logic led
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          w_level_nxt;
    logic          r_rise;
    logic          w_rise_nxt;
    logic          r_fall;
    logic          w_fall_nxt;

    // Two-flop synchronizer; r_sync2 is the only view of sw used below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // The first differing sample already counts as one, so acceptance happens
    // on the edge where the counter reads DEBOUNCE_CYCLES-1 and the sample is
    // still different; the counter therefore never reaches DEBOUNCE_CYCLES.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (r_sync2) begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = C_CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = C_CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                if (r_sync2) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign sw_level = r_level;
    assign sw_rise  = r_rise;
    assign sw_fall  = r_fall;

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    logic r_led;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 1'b0;
        end else if (r_rise) begin
            r_led <= ~r_led;
        end
    end

    assign led = r_led;
`else
    assign led = r_level;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debounce
// Description : Self-checking bench for switch_debounce (DEBOUNCE_CYCLES=4,
//               40 ns clock). Directed scenarios plus randomized switch
//               activity, all compared against a window-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_switch_debounce;

    localparam int unsigned N = 4;

    logic clk;
    logic rst_n;
    logic sw;
    logic sw_level;
    logic sw_rise;
    logic sw_fall;
    logic led;

    int n_tests;
    int n_fail;

    switch_debounce #(
        .DEBOUNCE_CYCLES(N)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .sw_level (sw_level),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .led      (led)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a level is accepted once the last N samples leaving
    // the two-stage synchronizer all disagree with the current level.
    // ------------------------------------------------------------------
    logic m_d1, m_d2;
    logic m_level, m_rise, m_fall, m_led;
    logic win[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1 = 1'b0; m_d2 = 1'b0;
            m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_led = 1'b0;
            win.delete();
        end else begin
            int diff;
            win.push_back(m_d2);
            if (win.size() > N) void'(win.pop_front());
            m_d2 = m_d1;
            m_d1 = sw;
            diff = 0;
            foreach (win[i]) if (win[i] != m_level) diff++;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (diff == N) begin
                m_level = ~m_level;
                m_rise  = m_level;
                m_fall  = ~m_level;
                win.delete();
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
                if (m_rise) m_led = ~m_led;
`endif
            end
`ifndef SWITCH_DEBOUNCE_TOGGLE_EN
            m_led = m_level;
`endif
        end
    end

    // Continuous comparison away from the active edge.
    always @(negedge clk) begin
        check("level", sw_level, m_level);
        check("rise",  sw_rise,  m_rise);
        check("fall",  sw_fall,  m_fall);
        check("led",   led,      m_led);
        check("rise_and_fall", sw_rise & sw_fall, 1'b0);
    end

    task automatic hold(input logic v, input int cycles);
        @(negedge clk);
        sw = v;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic seen;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sw      = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rst_level", sw_level, 1'b0);
        check("rst_rise",  sw_rise,  1'b0);
        check("rst_fall",  sw_fall,  1'b0);
        check("rst_led",   led,      1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle low for 20 cycles.
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            seen = seen | sw_level | sw_rise | sw_fall | led;
        end
        check("idle_quiet", seen, 1'b0);

        // Clean press: level/rise on the 6th edge, rise gone on the 7th.
        @(negedge clk);
        sw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i == 5) check("press_e5_level", sw_level, 1'b0);
        end
        check("press_e6_level", sw_level, 1'b1);
        check("press_e6_rise",  sw_rise,  1'b1);
        @(posedge clk); #1;
        check("press_e7_rise",  sw_rise,  1'b0);
        repeat (4) @(negedge clk);

        // Clean release: fall on the 6th edge for one cycle.
        @(negedge clk);
        sw = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("release_e6_fall",  sw_fall,  1'b1);
        check("release_e6_level", sw_level, 1'b0);
        @(posedge clk); #1;
        check("release_e7_fall",  sw_fall,  1'b0);
        repeat (4) @(negedge clk);

        // Bounce: 3 high / 1 low, five times, then low.
        seen = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                sw = (c < 3);
                seen = seen | sw_level | sw_rise | sw_fall;
            end
        end
        @(negedge clk);
        sw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | sw_level | sw_rise | sw_fall;
        end
        check("bounce_rejected", seen, 1'b0);

        // Reset during WAIT_HI discards the pending press.
        @(negedge clk);
        sw = 1'b1;
        repeat (5) @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        check("midwait_rst_level", sw_level, 1'b0);
        check("midwait_rst_rise",  sw_rise,  1'b0);
        check("midwait_rst_led",   led,      1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i == 5) check("post_rst_e5_rise", sw_rise, 1'b0);
        end
        check("post_rst_e6_rise",  sw_rise,  1'b1);
        check("post_rst_e6_level", sw_level, 1'b1);

        // Three presses from a fresh reset.
        hold(1'b0, 10);
        do_reset();
        for (int p = 1; p <= 3; p++) begin
            hold(1'b1, 10);
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
            check("toggle_led", led, (p % 2 == 1) ? 1'b1 : 1'b0);
`else
            check("follow_led", led, sw_level);
            check("follow_led_hi", led, 1'b1);
`endif
            hold(1'b0, 10);
        end

        // Randomized runs of 1..8 cycles with occasional resets.
        for (int r = 0; r < 250; r++) begin
            hold($urandom_range(0, 1) == 1, $urandom_range(1, 8));
            if ($urandom_range(0, 40) == 0) begin
                #3;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        hold(1'b0, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000 (10 ms at 25 MHz), meaning consecutive stable clock cycles required to accept a new switch level; legal range 2..2^24-1.
REQ-002 The block SHALL have port CLK  input  1  single system clock (25 MHz on the go-board).
REQ-003 The block SHALL have port RST_N  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 The block SHALL have port SW  input  1  raw push-button level, asynchronous to CLK, active-high (1 = pressed).
REQ-005 The block SHALL have port SW_LEVEL  output  1  debounced switch level.
REQ-006 The block SHALL have port SW_RISE  output  1  one-cycle pulse when SW_LEVEL goes 0->1.
REQ-007 The block SHALL have port SW_FALL  output  1  one-cycle pulse when SW_LEVEL goes 1->0.
REQ-008 The block SHALL have port LED  output  1  LED drive (see Configuration).

Function
REQ-009 The block SHALL pass SW through a two-flop synchronizer; the second flop output is the sync sample, and no other logic samples SW directly.
REQ-010 The block SHALL implement FSM states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO, plus a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-011 In STABLE_LO/STABLE_HI, a sync sample that differs from the stable level SHALL move the FSM to WAIT_HI/WAIT_LO with counter = 1; otherwise the counter SHALL be held at 0.
REQ-012 In a WAIT state, a sync sample that is still different SHALL increment the counter, and a sample equal to the stable level SHALL return the FSM to the prior STABLE state with counter = 0 (glitch rejected; no output change).
REQ-013 In a WAIT state with counter = DEBOUNCE_CYCLES-1 and a still-different sample, the block SHALL, on that edge: enter the opposite STABLE state, clear the counter, update SW_LEVEL, and assert the matching SW_RISE/SW_FALL.
REQ-014 The block SHALL change SW_LEVEL exactly 2+DEBOUNCE_CYCLES clock edges after a clean SW transition that is held steady.
REQ-015 The block SHALL keep SW_RISE and SW_FALL high for exactly one cycle per accepted transition, never both in the same cycle, and registered (no combinational path from SW).
REQ-016 The block SHALL ignore a bounce shorter than DEBOUNCE_CYCLES cycles entirely, regardless of how many times it repeats.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-018 When RST_N is low, the block SHALL immediately set both synchronizer flops to 0, FSM = STABLE_LO, counter = 0, SW_LEVEL = 0, SW_RISE = 0, SW_FALL = 0, and LED = 0.
REQ-019 Reset asserted mid-WAIT SHALL discard the pending transition; after release, a held SW=1 SHALL be accepted as a new 0->1 transition with full latency (REQ-014).
REQ-020 Reset release SHALL be treated as synchronous to CLK by the integrator; the block SHALL NOT generate pulses during reset.

Configuration
REQ-021 With macro SWITCH_DEBOUNCE_TOGGLE_EN defined, LED SHALL be a register that inverts on every cycle SW_RISE is asserted (press-to-toggle).
REQ-022 Without SWITCH_DEBOUNCE_TOGGLE_EN, LED SHALL equal SW_LEVEL, and the toggle register SHALL not be synthesized.

Verification (DEBOUNCE_CYCLES=4, CLK period 40 ns)
REQ-023 Reset then SW=0 for 20 cycles -> all outputs remain 0; FSM stays STABLE_LO.
REQ-024 SW 0->1 held -> SW_LEVEL=1 and SW_RISE=1 on the 6th edge after the change; SW_RISE=0 on the next edge.
REQ-025 SW pulses high for 3 cycles, low for 1, repeated 5 times, then low -> SW_LEVEL, SW_RISE, and SW_FALL all stay 0 throughout.
REQ-026 Accepted press, then SW=0 held -> SW_FALL=1 for one cycle 6 edges after release; SW_LEVEL=0.
REQ-027 SW=1 held, RST_N pulsed low at the 3rd cycle of WAIT_HI -> outputs 0 at once; after release, SW_RISE fires 6 edges later.
REQ-028 Three accepted presses: with TOGGLE_EN, LED = 1,0,1 after each press; without it, LED tracks SW_LEVEL exactly.
